// File: rtl/instr_loader.sv
// Boot loader: packs a valid/ready stream of program words into the flat
// instruction image for the cpu, holding the cpu in reset until loading ends.
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of accepted words).
`timescale 1ns/1ps

module instr_loader #(
  parameter int DEPTH  = 1024,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_word,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [DEPTH*WORD_W-1:0]   instruction_stream,
  output logic                      cpu_rst,
  output logic                      loaded,
  output logic [ADDR_W:0]           word_count,
  output logic [WORD_W-1:0]         checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic [ADDR_W:0]           word_count_q, word_count_d;
  logic [DEPTH*WORD_W-1:0]   stream_q, stream_d;
  logic                      in_ready_q, in_ready_d;
  logic                      cpu_rst_q, cpu_rst_d;
  logic                      loaded_q, loaded_d;
  logic                      accept;
  logic                      load_end;

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_W-1:0]         checksum_q, checksum_d;
`endif

  // in_ready_q is only ever high in LOAD, so accept needs no state qualifier.
  assign accept   = in_valid & in_ready_q;
  assign load_end = in_last | (ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    stream_d     = stream_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d      = LOAD;
          ptr_d        = '0;
          word_count_d = '0;
          stream_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end

      LOAD: begin
        if (accept) begin
          stream_d[ptr_q*WORD_W +: WORD_W] = in_word;
          word_count_d = word_count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q ^ in_word;
`endif
          // The pointer stops at the last slot rather than wrapping.
          if (load_end) state_d = DONE;
          else          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end

      DONE: state_d = RUN;

      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d = (state_d == LOAD);
    cpu_rst_d  = (state_d != RUN);
    loaded_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      word_count_q <= '0;
      // NOTE: the image is a register array that is deliberately reset; an
      // all-zero word is a nop, so the cpu never sees stale program data.
      stream_q     <= '0;
      in_ready_q   <= 1'b0;
      cpu_rst_q    <= 1'b1;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      stream_q     <= stream_d;
      in_ready_q   <= in_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      loaded_q     <= loaded_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign in_ready           = in_ready_q;
  assign instruction_stream = stream_q;
  assign cpu_rst            = cpu_rst_q;
  assign loaded             = loaded_q;
  assign word_count         = word_count_q;

endmodule
